alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single registered 4-bit ALU between two requesters, such as the instruction sequencer and the address/flag unit. The block arbitrates round-robin and drives the ALU opcode and operands. It waits out the ALU's one-cycle register latency, captures the result, and returns it over a valid/ready response channel tagged with the requester ID. It sits between the requesters and the ALU and is the ALU's only driver.

## Interface
- DATA_W, 4, operand/result width; matches the ALU.
- OP_W, 3, opcode width; matches the ALU.
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  request n accepted this cycle.
- req0_opcode / req1_opcode  in  OP_W  ALU opcode for requester n.
- req0_a / req1_a  in  DATA_W  first operand (in_1).
- req0_b / req1_b  in  DATA_W  second operand (in_2).
- rsp_valid  out  1  response holds a result.
- rsp_ready  in  1  response consumer accepts.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  DATA_W  captured ALU result.
- alu_opcode  out  OP_W  drives ALU opcode.
- alu_in_1 / alu_in_2  out  DATA_W  drive ALU operands.
- alu_result  in  DATA_W  ALU registered output.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. The reset state is IDLE.
- **IDLE**
  - The grant is combinational from req0_valid, req1_valid and last_grant.
  - One valid request: that requester wins.
  - Both requests valid: the requester not equal to last_grant wins.
  - reqN_ready is high only in IDLE, and only for the winner.
  - On the accept edge: latch opcode/a/b into the alu_* drive registers, record owner, update last_grant to the winner, go to ISSUE.
- **ISSUE**: the drive registers stay stable; the ALU samples them on this edge. Go to WAIT.
- **WAIT**: alu_result is valid. On the edge, capture it into rsp_data, set rsp_id = owner and rsp_valid = 1, go to RESP.
- **RESP**
  - rsp_valid stays high, and rsp_data/rsp_id stay stable, until a cycle with rsp_ready = 1.
  - On that edge: clear rsp_valid and go to IDLE.
  - No new request is accepted in RESP. The earliest next accept is the cycle after the handshake.
- Requester rules:
  - A requester holds valid, opcode and operands stable until its ready is seen.
  - Deasserting valid before ready is allowed; the request is simply not taken.
- Opcodes pass through unmodified. Arithmetic wraps modulo 2^DATA_W inside the ALU; the arbiter does not check or widen results.
- last_grant resets to 1, so requester 0 wins the first contended arbitration.
- Reset mid-operation (rst_n low in any state):
  - Immediately: FSM to IDLE, rsp_valid = 0, req ready = 0.
  - The in-flight transaction is discarded and produces no response.

## Timing
- Reset values: req0_ready = req1_ready = 0 (combinational, but forced 0 while rst_n low), rsp_valid = 0, rsp_id = 0, rsp_data = 0, alu_opcode = 0, alu_in_1 = alu_in_2 = 0, last_grant = 1.
- Accept edge E0 → ALU samples at E1 → rsp_valid high after E2. Latency is 2 cycles from accept to response.
- Throughput is one operation per 4 cycles when rsp_ready is tied high.
- Simultaneous req0/req1 in IDLE: exactly one ready asserts. The loser keeps valid and is granted on the next IDLE.
- With both requesters continuously valid, grants strictly alternate 0,1,0,1.

## Configuration
- ALU_ARB_ZERO_FLAG_EN
  - Defined: adds output rsp_zero (1 bit), registered with rsp_data in WAIT, equal to (alu_result == 0). It resets to 0 and is valid with rsp_valid.
  - Undefined: no rsp_zero port and no extra logic; behaviour is otherwise identical.

## Structure
- Shared package alu_pkg:
  - Parameters DATA_W and OP_W.
  - Opcode constants: OP_PASS = 000, OP_ADD = 001, OP_SUB = 010, OP_NOT = 011, OP_OR = 100, OP_AND = 101, OP_XOR = 110, OP_SHL2 = 111.
  - FSM state typedef: IDLE, ISSUE, WAIT, RESP.
- One sub-module, rr_arb2: a two-input round-robin grant from valid[1:0] and last_grant, producing a one-hot grant. It is purely combinational; the last_grant register stays in alu_arbiter.
- The bench instantiates the real ALU behind alu_arbiter.

## Test plan
- Reset, then req0: OP_ADD, a = 3, b = 4 → req0_ready pulses; rsp_valid rises 2 cycles after accept with rsp_data = 7, rsp_id = 0.
- req1: OP_SUB, a = 2, b = 5 → rsp_data = 13 (wrap), rsp_id = 1; rsp_zero = 0 when the macro is defined.
- Both valid from reset, with req0 = OP_XOR 0xA^0x5 and req1 = OP_SHL2 a = 3 → req0 is served first (rsp_data = 15), then req1 (rsp_data = 12). Continued dual requests alternate 0,1,0,1.
- Hold rsp_ready = 0 for 5 cycles → rsp_valid, rsp_data and rsp_id stay stable, and no reqN_ready asserts. On release, one handshake occurs, then IDLE.
- Assert rst_n low during WAIT → all outputs go to reset values immediately, and no response follows after reset release.
- With the macro defined, OP_AND a = 0xC, b = 0x3 → rsp_data = 0 and rsp_zero = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/opcode widths, opcode encodings and the
// arbiter FSM state type.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_PASS = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b011;
    localparam logic [OP_W-1:0] OP_OR   = 3'b100;
    localparam logic [OP_W-1:0] OP_AND  = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_SHL2 = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant: purely combinational, one-hot output.
// The last_grant state is owned by the caller.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        // On contention the requester that did not win last time goes first.
        if (valid_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared registered ALU; returns results on a
// valid/ready channel. Define ALU_ARB_ZERO_FLAG_EN to add the rsp_zero output.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
`ifdef ALU_ARB_ZERO_FLAG_EN
    output logic              rsp_zero,
`endif
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_in_2,
    input  logic [DATA_W-1:0] alu_result
);

    arb_state_t        state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic [1:0]        grant;
    logic              accept;
    logic [OP_W-1:0]   alu_opcode_q;
    logic [DATA_W-1:0] alu_in_1_q, alu_in_2_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;

    rr_arb2 u_rr_arb2 (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Ready is combinational but explicitly held low while reset is asserted.
    assign accept     = rst_n && (state_q == IDLE) && (grant != 2'b00);
    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_opcode_q <= '0;
            alu_in_1_q   <= '0;
            alu_in_2_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= grant[1];
                owner_q      <= grant[1];
                alu_opcode_q <= grant[1] ? req1_opcode : req0_opcode;
                alu_in_1_q   <= grant[1] ? req1_a : req0_a;
                alu_in_2_q   <= grant[1] ? req1_b : req0_b;
            end
            // The ALU sampled the drive registers one edge ago, so its output is valid now.
            if (state_q == WAIT) begin
                rsp_id_q   <= owner_q;
                rsp_data_q <= alu_result;
            end
        end
    end

`ifdef ALU_ARB_ZERO_FLAG_EN
    logic rsp_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero_q <= 1'b0;
        end else if (state_q == WAIT) begin
            rsp_zero_q <= (alu_result == '0);
        end
    end

    assign rsp_zero = rsp_zero_q;
`endif

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_in_1   = alu_in_1_q;
    assign alu_in_2   = alu_in_2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a registered ALU model behind it.
// Honours ALU_ARB_ZERO_FLAG_EN when defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic              clk, rst_n;
    logic              req0_valid, req1_valid, req0_ready, req1_ready;
    logic [OP_W-1:0]   req0_opcode, req1_opcode, alu_opcode;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              rsp_valid, rsp_ready, rsp_id;
    logic [DATA_W-1:0] rsp_data, alu_in_1, alu_in_2, alu_result;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic              rsp_zero;
`endif

    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q[$];

    logic [1:0]        pend;
    logic [OP_W-1:0]   p_op[2];
    logic [DATA_W-1:0] p_a[2], p_b[2];
    logic              lg_m;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef ALU_ARB_ZERO_FLAG_EN
        .rsp_zero(rsp_zero),
`endif
        .alu_opcode(alu_opcode), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        int r;
        case (op)
            OP_PASS: r = int'(a);
            OP_ADD:  r = int'(a) + int'(b);
            OP_SUB:  r = int'(a) - int'(b) + 16;
            OP_NOT:  r = 15 - int'(a);
            OP_OR:   r = int'(a | b);
            OP_AND:  r = int'(a & b);
            OP_XOR:  r = int'(a ^ b);
            default: r = int'(a) * 4;
        endcase
        return DATA_W'(r % 16);
    endfunction

    // Registered ALU: one-cycle latency from operands to result.
    always @(posedge clk) alu_result <= alu_f(alu_opcode, alu_in_1, alu_in_2);

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Rotating-priority search starting after the last winner.
    function automatic int winner_model();
        int w;
        int c;
        w = -1;
        for (int k = 1; k <= 2; k++) begin
            c = (int'(lg_m) + k) % 2;
            if (w < 0 && pend[c]) w = c;
        end
        return w;
    endfunction

    task automatic drive_reqs();
        req0_valid = pend[0]; req0_opcode = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
        req1_valid = pend[1]; req1_opcode = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
    endtask

    task automatic set_req(input int r, input logic [OP_W-1:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        pend[r] = 1'b1; p_op[r] = op; p_a[r] = a; p_b[r] = b;
    endtask

    task automatic rand_req(input int r);
        set_req(r, OP_W'($urandom_range(0, 7)), DATA_W'($urandom_range(0, 15)),
                DATA_W'($urandom_range(0, 15)));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; pend = 2'b00; lg_m = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_alu_in_1", alu_in_1, 0);
        chk("rst_alu_in_2", alu_in_2, 0);
`ifdef ALU_ARB_ZERO_FLAG_EN
        chk("rst_rsp_zero", rsp_zero, 0);
`endif
        drive_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One arbitration round; entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_one(input int stall, input bit rst_mid);
        logic [1:0] exp_g;
        int         w;
        int         n;
        rsp_t       e;
        drive_reqs();
        @(negedge clk);
        w = winner_model();
        exp_g = 2'b00;
        if (w >= 0) exp_g[w] = 1'b1;
        chk("grant", {req1_ready, req0_ready}, exp_g);
        if (w < 0) begin
            @(posedge clk); #1;
            return;
        end
        e.id = w[0];
        e.data = alu_f(p_op[w], p_a[w], p_b[w]);
        exp_q.push_back(e);
        lg_m = w[0];
        pend[w] = 1'b0;
        @(posedge clk); #1;
        drive_reqs();
        if (rst_mid) begin
            @(posedge clk); #1;
            void'(exp_q.pop_back());
            apply_reset();
            repeat (6) begin
                @(negedge clk);
                chk("no_rsp_after_reset", rsp_valid, 0);
            end
            @(posedge clk); #1;
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!rsp_valid) chk("busy_ready", {req1_ready, req0_ready}, 0);
        end while (!rsp_valid && n < 8);
        chk("latency", n, 3);
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (n < stall) rsp_ready = 1'b0;
            else if (n >= stall + 8) rsp_ready = 1'b1;
            else rsp_ready = ($urandom_range(0, 2) != 0);
            n++;
            @(negedge clk);
            chk("rsp_valid_held", rsp_valid, 1);
            chk("resp_ready_gated", {req1_ready, req0_ready}, 0);
            if (rsp_ready) break;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold stability.
    logic mon_hold;
    rsp_t mon_held;
    rsp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_hold <= 1'b0;
        end else begin
            if (mon_hold) begin
                chk("stable_valid", rsp_valid, 1);
                chk("stable_id", rsp_id, mon_held.id);
                chk("stable_data", rsp_data, mon_held.data);
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%0d data=%0d expected none", rsp_id, rsp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, mon_e.id);
                    chk("rsp_data", rsp_data, mon_e.data);
`ifdef ALU_ARB_ZERO_FLAG_EN
                    chk("rsp_zero", rsp_zero, (mon_e.data == '0) ? 1 : 0);
`endif
                end
            end
            mon_hold <= rsp_valid && !rsp_ready;
            mon_held <= {rsp_id, rsp_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; rsp_ready = 1'b0; pend = 2'b00; lg_m = 1'b1;
        for (int r = 0; r < 2; r++) begin p_op[r] = '0; p_a[r] = '0; p_b[r] = '0; end
        drive_reqs();
        #2;
        apply_reset();

        set_req(0, OP_ADD, 4'd3, 4'd4);   run_one(0, 0);
        set_req(1, OP_SUB, 4'd2, 4'd5);   run_one(0, 0);

        apply_reset();
        set_req(0, OP_XOR, 4'hA, 4'h5);
        set_req(1, OP_SHL2, 4'd3, 4'd0);
        run_one(0, 0);
        run_one(0, 0);
        repeat (6) begin
            for (int r = 0; r < 2; r++) if (!pend[r]) rand_req(r);
            run_one(0, 0);
        end
        while (pend != 2'b00) run_one(0, 0);

        set_req(0, OP_ADD, 4'd9, 4'd9);
        set_req(1, OP_OR, 4'd1, 4'd2);
        run_one(5, 0);
        run_one(0, 0);

        set_req(0, OP_AND, 4'hC, 4'h3);   run_one(0, 0);

        set_req(1, OP_ADD, 4'd5, 4'd6);   run_one(0, 1);

        repeat (40) begin
            for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(0, 1) == 1) rand_req(r);
            run_one(int'($urandom_range(0, 2)), 0);
        end
        while (pend != 2'b00) run_one(0, 0);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
